// File: rtl/host_link_delay_queue_pkg.sv
// Shared host-link constants and the release-timestamp type for the default latency width.
package host_link_pkg;
  localparam int PCIE_WIDTH         = 64;
  localparam int SOFTREG_ADDR_WIDTH = 64;
  localparam int SOFTREG_DATA_WIDTH = 64;
  localparam int UMI_ADDR_WIDTH     = 64;
  localparam int UMI_DATA_WIDTH     = 256;

  localparam int HL_LAT_W   = 8;
  localparam int HL_STAMP_W = HL_LAT_W + 1;

  typedef logic [HL_STAMP_W-1:0] stamp_t;
endpackage

// File: rtl/host_link_entry_ram.sv
// Entry storage: payload plus release stamp per slot, one write and one read port.
// Stamps are also tapped out in parallel so the top can run per-entry maturity compares.
module host_link_entry_ram #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 64,
  parameter  int SW    = 9,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      we_i,
  input  logic [AW-1:0]             waddr_i,
  input  logic [WIDTH-1:0]          wbits_i,
  input  logic [SW-1:0]             wstamp_i,
  input  logic [AW-1:0]             raddr_i,
  output logic [WIDTH-1:0]          rbits_o,
  output logic [DEPTH-1:0][SW-1:0]  stamps_o
);
  logic [DEPTH-1:0][WIDTH-1:0] bits_q;
  logic [DEPTH-1:0][SW-1:0]    stamp_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bits_q  <= '0;
      stamp_q <= '0;
    end else if (we_i) begin
      bits_q[waddr_i]  <= wbits_i;
      stamp_q[waddr_i] <= wstamp_i;
    end
  end

  assign rbits_o  = bits_q[raddr_i];
  assign stamps_o = stamp_q;
endmodule

// File: rtl/host_link_delay_queue.sv
// Cycle-accurate host-link latency model: FIFO whose entries become visible L+1 cycles after enqueue.
// Define HOST_LINK_STATS_EN to add saturating enqueue / full-stall / out-stall counters.
module host_link_delay_queue
  import host_link_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int LAT_W = HL_LAT_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [LAT_W-1:0]         cfg_latency,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_bits,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_bits,
  output logic [$clog2(DEPTH):0]   count
`ifdef HOST_LINK_STATS_EN
  ,
  output logic [31:0]              stat_enq,
  output logic [31:0]              stat_full_stall,
  output logic [31:0]              stat_out_stall
`endif
);
  localparam int STAMP_W = LAT_W + 1;
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;

  typedef logic [STAMP_W-1:0] stamp_w_t;

  stamp_w_t                    now_q, now_nxt;
  logic [AW-1:0]               head_q, tail_q, tail_idx;
  logic [CW-1:0]               count_q;
  logic [DEPTH-1:0]            mature_q, mature_d;
  logic [DEPTH-1:0][STAMP_W-1:0] stamps;
  logic                        enq, deq, tail_pend;
  stamp_w_t                    cand, tail_stamp, dist_c, dist_t, new_stamp;

  assign in_ready  = !reset && (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0) && mature_q[head_q];
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;
  assign count     = count_q;
  assign now_nxt   = now_q + stamp_w_t'(1);

  assign tail_idx   = tail_q - AW'(1);
  assign tail_stamp = stamps[tail_idx];
  assign tail_pend  = (count_q != '0) && !mature_q[tail_idx];

  // Stamps are compared as distance ahead of now, so the later-of choice survives wrap.
  always_comb begin
    cand      = now_q + {1'b0, cfg_latency} + stamp_w_t'(1);
    dist_c    = cand - now_q;
    dist_t    = tail_stamp - now_q;
    new_stamp = cand;
    if (tail_pend && (dist_t > dist_c)) new_stamp = tail_stamp;
  end

  // Maturity is evaluated against next cycle's now so out_valid rises in the cycle now == stamp.
  always_comb begin
    mature_d = mature_q;
    for (int i = 0; i < DEPTH; i++)
      if (stamps[i] == now_nxt) mature_d[i] = 1'b1;
    if (deq) mature_d[head_q] = 1'b0;
    if (enq) mature_d[tail_q] = (new_stamp == now_nxt);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      now_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      mature_q <= '0;
    end else begin
      now_q    <= now_nxt;
      mature_q <= mature_d;
      if (enq) tail_q <= tail_q + AW'(1);
      if (deq) head_q <= head_q + AW'(1);
      if (enq && !deq)      count_q <= count_q + CW'(1);
      else if (!enq && deq) count_q <= count_q - CW'(1);
    end
  end

  host_link_entry_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .SW    (STAMP_W)
  ) u_ram (
    .clock    (clock),
    .reset    (reset),
    .we_i     (enq),
    .waddr_i  (tail_q),
    .wbits_i  (in_bits),
    .wstamp_i (new_stamp),
    .raddr_i  (head_q),
    .rbits_o  (out_bits),
    .stamps_o (stamps)
  );

`ifdef HOST_LINK_STATS_EN
  logic [31:0] stat_enq_q, stat_full_q, stat_out_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_enq_q  <= '0;
      stat_full_q <= '0;
      stat_out_q  <= '0;
    end else begin
      if (enq && (stat_enq_q != '1))                        stat_enq_q  <= stat_enq_q + 32'd1;
      if (in_valid && !in_ready && (stat_full_q != '1))     stat_full_q <= stat_full_q + 32'd1;
      if (out_valid && !out_ready && (stat_out_q != '1))    stat_out_q  <= stat_out_q + 32'd1;
    end
  end

  assign stat_enq        = stat_enq_q;
  assign stat_full_stall = stat_full_q;
  assign stat_out_stall  = stat_out_q;
`endif
endmodule

// File: tb/tb_host_link_delay_queue.sv
// Scoreboard bench for host_link_delay_queue: release cycles modelled from enqueue cycle and latency.
module tb_host_link_delay_queue;
  localparam int WIDTH = 64;
  localparam int DEPTH = 16;
  localparam int LAT_W = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [LAT_W-1:0] cfg_latency = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_bits = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_bits;
  logic [$clog2(DEPTH):0] count;
`ifdef HOST_LINK_STATS_EN
  logic [31:0] stat_enq, stat_full_stall, stat_out_stall;
`endif

  host_link_delay_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LAT_W(LAT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .cfg_latency (cfg_latency),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_bits     (in_bits),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_bits    (out_bits),
    .count       (count)
`ifdef HOST_LINK_STATS_EN
    ,
    .stat_enq        (stat_enq),
    .stat_full_stall (stat_full_stall),
    .stat_out_stall  (stat_out_stall)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { logic [63:0] d; int rel; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0, n_err = 0;
  bit   tchk = 0;
  int   last_rel = 0;
  int   prev_pop = -100;
  int   lows;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pop side: data always checked; pop cycle checked while the consumer is continuously ready.
  always @(negedge clock) begin
    if (reset) prev_pop = -100;
    else if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else begin
        mon_e = sb.pop_front();
        chk("out_bits", out_bits, mon_e.d);
        if (tchk) chk("pop_cyc", 64'(cyc), 64'((mon_e.rel > prev_pop + 1) ? mon_e.rel : prev_pop + 1));
      end
      prev_pop = cyc;
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic push(input logic [63:0] d, input int lat);
    int tries = 0;
    int rel;
    bit acc = 0;
    in_valid = 1'b1; in_bits = d; cfg_latency = LAT_W'(lat);
    while (!acc && tries < 2000) begin
      @(negedge clock);
      if (in_ready) begin
        rel = cyc + 1 + lat;
        if (last_rel > rel) rel = last_rel;
        last_rel = rel;
        sb.push_back('{d, rel});
        acc = 1;
      end
      tries++;
      step();
    end
    in_valid = 1'b0;
    if (!acc) chk("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin step(); n++; end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_bits", out_bits, 64'd0);
    repeat (3) step();
    reset = 1'b0;
    @(negedge clock);
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    step();

    // Zero latency: single register stage
    out_ready = 1'b1; tchk = 1;
    repeat (5) step();
    push(64'hA5, 0);
    @(negedge clock);
    chk("l0_valid", 64'(out_valid), 64'd1);
    chk("l0_count", 64'(count), 64'd1);
    step();
    @(negedge clock);
    chk("l0_count_empty", 64'(count), 64'd0);
    step();

    // Burst at latency 5
    for (int i = 0; i < 4; i++) push({$urandom, $urandom}, 5);
    drain();

    // Latency drop must not let B overtake A
    push(64'hAAAA_0001, 20);
    push(64'hBBBB_0002, 2);
    drain();

    // Fill to DEPTH with consumer stalled
    out_ready = 1'b0; tchk = 0;
    for (int i = 0; i < DEPTH; i++) push(64'h1000 + 64'(i), 0);
    @(negedge clock);
    chk("full_count", 64'(count), 64'(DEPTH));
    chk("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_bits = 64'hDEAD_0017;
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clock);
      chk("full_hold_count", 64'(count), 64'(DEPTH));
    end
    step();
    out_ready = 1'b1; in_valid = 1'b0;
    step();
    @(negedge clock);
    chk("after_pop_ready", 64'(in_ready), 64'd1);
    chk("after_pop_count", 64'(count), 64'(DEPTH - 1));
    step();
    push(64'hDEAD_0017, 0);
    drain();

    // Matured head stalled across now wrap
    out_ready = 1'b0;
    push(64'h5EED_CAFE_0600_0001, 0);
    lows = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      if (!out_valid) lows++;
      step();
    end
    chk("hold_valid_lows", 64'(lows), 64'd0);
    out_ready = 1'b1;
    drain();

    // Async reset with 7 matured entries queued
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) push(64'h7700 + 64'(i), 1);
    repeat (3) step();
    @(negedge clock);
    chk("pre_rst_count", 64'(count), 64'd7);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_bits", out_bits, 64'd0);
`ifdef HOST_LINK_STATS_EN
    chk("stat_enq_rst", 64'(stat_enq), 64'd0);
    chk("stat_full_rst", 64'(stat_full_stall), 64'd0);
    chk("stat_out_rst", 64'(stat_out_stall), 64'd0);
`endif
    sb.delete();
    last_rel = 0;
    repeat (2) step();
    reset = 1'b0;
    out_ready = 1'b1; tchk = 1;
    step();
    push(64'h3C3C, 3);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
